// File: rtl/fifo_sync_prog_if.sv
// fifo_sync_prog_if: producer/consumer bundle for the sync FIFO.
// master drives requests, slave returns data and status.
interface fifo_sync_prog_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  i_winc;
  logic [DATA_WIDTH-1:0] i_wdata;
  logic                  i_rinc;
  logic                  i_clr_err;
  logic [DATA_WIDTH-1:0] o_rdata;
  logic                  o_wfull;
  logic                  o_rempty;
  logic                  o_walmost_full;
  logic                  o_ralmost_empty;
  logic [ADDR_WIDTH:0]   o_count;
  logic                  o_overflow;
  logic                  o_underflow;

  modport master (
    output i_winc, i_wdata, i_rinc, i_clr_err,
    input  o_rdata, o_wfull, o_rempty,
    input  o_walmost_full, o_ralmost_empty,
    input  o_count, o_overflow, o_underflow
  );

  modport slave (
    input  i_winc, i_wdata, i_rinc, i_clr_err,
    output o_rdata, o_wfull, o_rempty,
    output o_walmost_full, o_ralmost_empty,
    output o_count, o_overflow, o_underflow
  );
endinterface

// File: rtl/fifo_sync_prog.sv
// fifo_sync_prog: single-clock FIFO with registered count,
// programmable almost flags, FWFT option and sticky errors.
module fifo_sync_prog #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter bit FWFT          = 1'b0,
  parameter int AFULL_THRESH  = 12,
  parameter int AEMPTY_THRESH = 2
) (
  input logic              i_clk,
  input logic              i_rst_n,
  fifo_sync_prog_if.slave  bus
);

  localparam int AW = ADDR_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam int DEPTH = 1 << AW;

  typedef logic [AW:0] ptr_t;

  logic [DW-1:0] mem [DEPTH];

  ptr_t wptr_q, wptr_d;
  ptr_t rptr_q, rptr_d;
  ptr_t count_q, count_d;
  logic full_q, full_d;
  logic empty_q, empty_d;
  logic afull_q, afull_d;
  logic aempty_q, aempty_d;
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;
  logic wr_ok, rd_ok;

  // Accept decisions and next-state occupancy, all from pre-edge flags
  always_comb begin
    wr_ok  = bus.i_winc & ~full_q;
    rd_ok  = bus.i_rinc & ~empty_q;
    wptr_d = wptr_q + ptr_t'(wr_ok);
    rptr_d = rptr_q + ptr_t'(rd_ok);
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + ptr_t'(1);
      2'b01:   count_d = count_q - ptr_t'(1);
      default: count_d = count_q;
    endcase
    full_d   = (wptr_d[AW] != rptr_d[AW]) &&
               (wptr_d[AW-1:0] == rptr_d[AW-1:0]);
    empty_d  = (wptr_d == rptr_d);
    afull_d  = (count_d >= ptr_t'(AFULL_THRESH));
    aempty_d = (count_d <= ptr_t'(AEMPTY_THRESH));
    ovf_d    = (bus.i_winc & full_q) |
               (ovf_q & ~bus.i_clr_err);
    unf_d    = (bus.i_rinc & empty_q) |
               (unf_q & ~bus.i_clr_err);
  end

  // Pointer, count and flag registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage array; contents are not cleared by reset
  always_ff @(posedge i_clk) begin
    if (wr_ok) mem[wptr_q[AW-1:0]] <= bus.i_wdata;
  end

  if (FWFT) begin : g_fwft
    assign bus.o_rdata = mem[rptr_q[AW-1:0]];
  end else begin : g_reg
    logic [DW-1:0] rdata_q, rdata_d;

    // Capture the head word only when a pop is accepted
    always_comb begin
      rdata_d = rdata_q;
      if (rd_ok) rdata_d = mem[rptr_q[AW-1:0]];
    end

    // Registered read data
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) rdata_q <= '0;
      else          rdata_q <= rdata_d;
    end

    assign bus.o_rdata = rdata_q;
  end

  assign bus.o_count         = count_q;
  assign bus.o_wfull         = full_q;
  assign bus.o_rempty        = empty_q;
  assign bus.o_walmost_full  = afull_q;
  assign bus.o_ralmost_empty = aempty_q;
  assign bus.o_overflow      = ovf_q;
  assign bus.o_underflow     = unf_q;

endmodule

// File: tb/tb_fifo_sync_prog.sv
// tb_fifo_sync_prog: directed vectors plus a queue model
// for fifo_sync_prog in registered and FWFT read modes.
module tb_fifo_sync_prog;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  fifo_sync_prog_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) if0 ();
  fifo_sync_prog_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) if1 ();

  fifo_sync_prog #(.FWFT(1'b0)) dut0 (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (if0)
  );

  fifo_sync_prog #(.FWFT(1'b1)) dut1 (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (if1)
  );

  typedef struct {
    bit       w;
    bit [7:0] d;
    bit       r;
    bit       clr;
    int       cnt;
    bit       full;
    bit       empty;
    bit       af;
    bit       ae;
    bit       ovf;
    bit       unf;
    bit       chk_rd;
    bit [7:0] rd;
  } vec_t;

  vec_t vecs [38];

  int checks = 0;
  int errors = 0;

  logic [7:0] mq [$];
  logic [7:0] m_rdata;
  bit         m_ovf;
  bit         m_unf;

  task automatic chk(input string nm, input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  task automatic drive0(input bit w, input logic [7:0] d,
                        input bit r, input bit clr);
    if0.i_winc    = w;
    if0.i_wdata   = d;
    if0.i_rinc    = r;
    if0.i_clr_err = clr;
  endtask

  task automatic drive1(input bit w, input logic [7:0] d,
                        input bit r, input bit clr);
    if1.i_winc    = w;
    if1.i_wdata   = d;
    if1.i_rinc    = r;
    if1.i_clr_err = clr;
  endtask

  // One clock of dut0 checked against the queue model
  task automatic op(input bit w, input logic [7:0] d,
                    input bit r, input bit clr,
                    input string nm);
    bit wok, rok, full, empty;
    int n;
    full  = (mq.size() == 16);
    empty = (mq.size() == 0);
    wok   = w && !full;
    rok   = r && !empty;
    drive0(w, d, r, clr);
    @(posedge clk);
    #1;
    m_ovf = (w && full) || (m_ovf && !clr);
    m_unf = (r && empty) || (m_unf && !clr);
    if (rok) m_rdata = mq.pop_front();
    if (wok) mq.push_back(d);
    n = mq.size();
    chk({nm, " count"}, int'(if0.o_count), n);
    chk({nm, " full"}, int'(if0.o_wfull), int'(n == 16));
    chk({nm, " empty"}, int'(if0.o_rempty), int'(n == 0));
    chk({nm, " afull"}, int'(if0.o_walmost_full),
        int'(n >= 12));
    chk({nm, " aempty"}, int'(if0.o_ralmost_empty),
        int'(n <= 2));
    chk({nm, " ovf"}, int'(if0.o_overflow), int'(m_ovf));
    chk({nm, " unf"}, int'(if0.o_underflow), int'(m_unf));
    chk({nm, " rdata"}, int'(if0.o_rdata), int'(m_rdata));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Fill 16, overflow, clear, drain 16, underflow, clear
    for (int i = 0; i < 16; i++) begin
      vecs[i] = '{1, 8'h10 + 8'(i), 0, 0, i + 1, i == 15,
                  0, (i + 1) >= 12, (i + 1) <= 2, 0, 0,
                  0, 8'h00};
    end
    vecs[16] = '{1, 8'hFF, 0, 0, 16, 1, 0, 1, 0, 1, 0,
                 0, 8'h00};
    vecs[17] = '{1, 8'hEE, 0, 1, 16, 1, 0, 1, 0, 1, 0,
                 0, 8'h00};
    vecs[18] = '{0, 8'h00, 0, 1, 16, 1, 0, 1, 0, 0, 0,
                 0, 8'h00};
    for (int j = 0; j < 16; j++) begin
      vecs[19 + j] = '{0, 8'h00, 1, 0, 15 - j, 0, j == 15,
                       (15 - j) >= 12, (15 - j) <= 2, 0, 0,
                       1, 8'h10 + 8'(j)};
    end
    vecs[35] = '{0, 8'h00, 1, 0, 0, 0, 1, 0, 1, 0, 1,
                 1, 8'h1F};
    vecs[36] = '{0, 8'h00, 1, 1, 0, 0, 1, 0, 1, 0, 1,
                 1, 8'h1F};
    vecs[37] = '{0, 8'h00, 0, 1, 0, 0, 1, 0, 1, 0, 0,
                 1, 8'h1F};

    drive0(0, 8'h00, 0, 0);
    drive1(0, 8'h00, 0, 0);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst count", int'(if0.o_count), 0);
    chk("rst empty", int'(if0.o_rempty), 1);
    chk("rst full", int'(if0.o_wfull), 0);
    chk("rst aempty", int'(if0.o_ralmost_empty), 1);
    chk("rst afull", int'(if0.o_walmost_full), 0);
    chk("rst ovf", int'(if0.o_overflow), 0);
    chk("rst unf", int'(if0.o_underflow), 0);
    chk("rst rdata", int'(if0.o_rdata), 0);
    chk("rst fwft empty", int'(if1.o_rempty), 1);
    rst_n = 1'b1;

    // Table-driven fill/drain/error vectors
    foreach (vecs[k]) begin
      drive0(vecs[k].w, vecs[k].d, vecs[k].r, vecs[k].clr);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d count", k),
          int'(if0.o_count), vecs[k].cnt);
      chk($sformatf("vec%0d full", k),
          int'(if0.o_wfull), int'(vecs[k].full));
      chk($sformatf("vec%0d empty", k),
          int'(if0.o_rempty), int'(vecs[k].empty));
      chk($sformatf("vec%0d afull", k),
          int'(if0.o_walmost_full), int'(vecs[k].af));
      chk($sformatf("vec%0d aempty", k),
          int'(if0.o_ralmost_empty), int'(vecs[k].ae));
      chk($sformatf("vec%0d ovf", k),
          int'(if0.o_overflow), int'(vecs[k].ovf));
      chk($sformatf("vec%0d unf", k),
          int'(if0.o_underflow), int'(vecs[k].unf));
      if (vecs[k].chk_rd)
        chk($sformatf("vec%0d rdata", k),
            int'(if0.o_rdata), int'(vecs[k].rd));
    end

    m_rdata = 8'h1F;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;

    // Simultaneous push/pop at count 5
    for (int i = 0; i < 5; i++)
      op(1, 8'h20 + 8'(i), 0, 0, "pre5");
    op(1, 8'h25, 1, 0, "simul5");
    chk("simul5 hand count", int'(if0.o_count), 5);
    chk("simul5 hand rdata", int'(if0.o_rdata), 8'h20);

    // Simultaneous push/pop when full
    for (int i = 0; i < 11; i++)
      op(1, 8'h40 + 8'(i), 0, 0, "tofull");
    op(1, 8'h99, 1, 0, "simulfull");
    chk("simulfull hand count", int'(if0.o_count), 15);
    chk("simulfull hand ovf", int'(if0.o_overflow), 1);
    op(0, 8'h00, 0, 1, "clr1");
    for (int i = 0; i < 15; i++)
      op(0, 8'h00, 1, 0, "drain15");

    // Simultaneous push/pop when empty
    op(1, 8'h77, 1, 0, "simulempty");
    chk("simulempty hand count", int'(if0.o_count), 1);
    chk("simulempty hand unf", int'(if0.o_underflow), 1);
    op(0, 8'h00, 0, 1, "clr2");
    op(0, 8'h00, 1, 0, "pop77");
    chk("pop77 hand rdata", int'(if0.o_rdata), 8'h77);

    // Random-rate traffic across the pointer wrap
    for (int i = 0; i < 40; i++) begin
      bit w, r;
      w = ($urandom_range(0, 9) < (i < 20 ? 7 : 3));
      r = ($urandom_range(0, 9) < (i < 20 ? 3 : 7));
      op(w, 8'($urandom), r, 0, "wrap");
      if (if0.o_count > 16)
        chk("wrap bound", int'(if0.o_count), 16);
    end
    for (int i = 0; i < 16; i++)
      op(0, 8'h00, 1, 0, "wrapdrain");
    op(0, 8'h00, 0, 1, "clr3");

    // Reset in the middle of a burst
    for (int i = 0; i < 3; i++)
      op(1, 8'h60 + 8'(i), 0, 0, "burst");
    drive0(1, 8'h63, 0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst count", int'(if0.o_count), 0);
    chk("midrst empty", int'(if0.o_rempty), 1);
    chk("midrst aempty", int'(if0.o_ralmost_empty), 1);
    chk("midrst rdata", int'(if0.o_rdata), 0);
    drive0(0, 8'h00, 0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mq.delete();
    m_rdata = 8'h00;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
    op(1, 8'h5A, 0, 0, "post rst wr");
    op(0, 8'h00, 1, 0, "post rst rd");
    chk("post rst hand rdata", int'(if0.o_rdata), 8'h5A);
    op(0, 8'h00, 0, 0, "post rst idle");

    // FWFT instance: fall-through visibility and pop
    drive1(1, 8'hA5, 0, 0);
    @(posedge clk);
    #1;
    drive1(0, 8'h00, 0, 0);
    chk("fwft rdata", int'(if1.o_rdata), 8'hA5);
    chk("fwft empty", int'(if1.o_rempty), 0);
    chk("fwft count", int'(if1.o_count), 1);
    drive1(1, 8'h3C, 0, 0);
    @(posedge clk);
    #1;
    chk("fwft hold", int'(if1.o_rdata), 8'hA5);
    chk("fwft count2", int'(if1.o_count), 2);
    drive1(0, 8'h00, 1, 0);
    @(posedge clk);
    #1;
    chk("fwft pop1", int'(if1.o_rdata), 8'h3C);
    chk("fwft count3", int'(if1.o_count), 1);
    @(posedge clk);
    #1;
    drive1(0, 8'h00, 0, 0);
    chk("fwft pop2 empty", int'(if1.o_rempty), 1);
    chk("fwft pop2 count", int'(if1.o_count), 0);
    chk("fwft unf", int'(if1.o_underflow), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
